apb_i2c_regfile: RTL and testbench

Parametrised APB slave register bank that sits between the APB bus and the I2C core, FIFOs and clock generator. It supersedes ad-hoc command-bit FIFO strobing: TX push and RX pop are generated from data-register accesses. It also adds programmable wait states, PSLVERR error responses, sticky error flags and an optional interrupt.

---
 rtl/apb_i2c_regfile.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_apb_i2c_regfile.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_i2c_regfile.sv
// APB slave register bank for the I2C core: config registers, TX/RX FIFO
// strobes from data-register accesses, wait states, PSLVERR and sticky errors.
// Optional interrupt logic is built when I2C_APB_IRQ_EN is defined.
module apb_i2c_regfile #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned WAIT_STATES  = 0,
    parameter int unsigned PRESCALE_RST = 4
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [DATA_WIDTH-1:0] prescale_reg,
    output logic [DATA_WIDTH-1:0] address_reg,
    output logic                  core_enable,
    output logic                  core_rst_n,
    output logic                  repeated_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_push,
    output logic                  rx_pop,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  tx_full,
    input  logic                  tx_empty,
    input  logic                  rx_full,
    input  logic                  rx_empty,
    input  logic                  busy,
    input  logic                  nack,
    output logic                  irq
);

    localparam int unsigned WAIT_W = 4;
    localparam int unsigned IDX_W  = 3;

    localparam logic [IDX_W-1:0] REG_PRESCALE = 3'd0;
    localparam logic [IDX_W-1:0] REG_COMMAND  = 3'd1;
    localparam logic [IDX_W-1:0] REG_STATUS   = 3'd2;
    localparam logic [IDX_W-1:0] REG_TXDATA   = 3'd3;
    localparam logic [IDX_W-1:0] REG_RXDATA   = 3'd4;
    localparam logic [IDX_W-1:0] REG_ADDRESS  = 3'd5;
    localparam logic [IDX_W-1:0] REG_IRQ_EN   = 3'd6;
    localparam logic [IDX_W-1:0] REG_IRQ_STAT = 3'd7;

    // IDLE also covers the bus setup cycle; ACCESS holds the wait states;
    // DONE is the single PREADY-high cycle in which the access commits.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                load, commit;
    logic                pready_d, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_d;

    // Decoded access, evaluated in the cycle before PREADY rises
    logic [IDX_W-1:0]      idx;
    logic                  addr_hi_bad;
    logic                  dec_err, dec_wr, dec_push, dec_pop, dec_ovf, dec_unf;
    logic [DATA_WIDTH-1:0] dec_rdata;
    logic [7:0]            status_bits;

    // Access decisions held into the commit cycle
    logic [IDX_W-1:0] op_idx_q;
    logic             op_wr_q, op_push_q, op_pop_q, op_ovf_q, op_unf_q;

    logic [DATA_WIDTH-1:0] prescale_q, address_q;
    logic                  cmd_enable_q, cmd_rst_n_q, cmd_rstart_q;
`ifdef I2C_APB_IRQ_EN
    logic [3:0]            irq_en_q;
`endif

    // Stickies are {nack, ovf, unf}
    logic [2:0] sticky_q, sticky_d, sticky_set, sticky_clr;
    logic       nack_q, nack_rise_q;

    assign idx         = PADDR[IDX_W-1:0];
    assign addr_hi_bad = (PADDR >> IDX_W) != '0;
    assign status_bits = {tx_full, tx_empty, rx_full, rx_empty, busy, sticky_q};

    // Access decode: error, read data and side effects for the current address
    always_comb begin
        dec_err   = 1'b0;
        dec_wr    = 1'b0;
        dec_push  = 1'b0;
        dec_pop   = 1'b0;
        dec_ovf   = 1'b0;
        dec_unf   = 1'b0;
        dec_rdata = '0;
        if (addr_hi_bad) begin
            dec_err = 1'b1;
        end else if (PWRITE) begin
            case (idx)
                REG_PRESCALE, REG_COMMAND, REG_ADDRESS, REG_IRQ_STAT: dec_wr = 1'b1;
`ifdef I2C_APB_IRQ_EN
                REG_IRQ_EN: dec_wr = 1'b1;
`endif
                REG_TXDATA: begin
                    if (tx_full) begin
                        dec_err = 1'b1;
                        dec_ovf = 1'b1;
                    end else begin
                        dec_push = 1'b1;
                    end
                end
                default: dec_err = 1'b1;
            endcase
        end else begin
            case (idx)
                REG_PRESCALE: dec_rdata = prescale_q;
                REG_COMMAND:  dec_rdata = DATA_WIDTH'({cmd_enable_q, 2'b00, cmd_rst_n_q,
                                                       cmd_rstart_q, 3'b000});
                REG_STATUS:   dec_rdata = DATA_WIDTH'(status_bits);
                REG_TXDATA:   dec_err   = 1'b1;
                REG_RXDATA: begin
                    if (rx_empty) begin
                        dec_err = 1'b1;
                        dec_unf = 1'b1;
                    end else begin
                        dec_rdata = rx_data;
                        dec_pop   = 1'b1;
                    end
                end
                REG_ADDRESS:  dec_rdata = address_q;
`ifdef I2C_APB_IRQ_EN
                REG_IRQ_EN:   dec_rdata = DATA_WIDTH'(irq_en_q);
`endif
                REG_IRQ_STAT: dec_rdata = DATA_WIDTH'(sticky_q);
                default:      dec_rdata = '0;
            endcase
        end
    end

    // Access FSM next state and registered bus response
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        load      = 1'b0;
        commit    = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (PSELx && !PENABLE) begin
                    wait_d = WAIT_W'(1);
                    if (WAIT_STATES == 0) begin
                        state_d = ST_DONE;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (!PSELx) begin
                    state_d = ST_IDLE;
                end else if (wait_q == WAIT_W'(WAIT_STATES)) begin
                    state_d = ST_DONE;
                    load    = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                commit  = PSELx;
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            pready_d  = 1'b1;
            pslverr_d = dec_err;
            prdata_d  = dec_rdata;
        end
    end

    // FSM state, bus response and latched access decisions
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            PREADY    <= 1'b0;
            PSLVERR   <= 1'b0;
            PRDATA    <= '0;
            op_idx_q  <= '0;
            op_wr_q   <= 1'b0;
            op_push_q <= 1'b0;
            op_pop_q  <= 1'b0;
            op_ovf_q  <= 1'b0;
            op_unf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            PREADY  <= pready_d;
            PSLVERR <= pslverr_d;
            PRDATA  <= prdata_d;
            if (load) begin
                op_idx_q  <= idx;
                op_wr_q   <= dec_wr;
                op_push_q <= dec_push;
                op_pop_q  <= dec_pop;
                op_ovf_q  <= dec_ovf;
                op_unf_q  <= dec_unf;
            end
        end
    end

    // Configuration registers, TX data and FIFO strobes, updated on commit
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            prescale_q   <= DATA_WIDTH'(PRESCALE_RST);
            address_q    <= '0;
            cmd_enable_q <= 1'b0;
            cmd_rst_n_q  <= 1'b0;
            cmd_rstart_q <= 1'b0;
`ifdef I2C_APB_IRQ_EN
            irq_en_q     <= '0;
`endif
            tx_data      <= '0;
            tx_push      <= 1'b0;
            rx_pop       <= 1'b0;
        end else begin
            tx_push <= commit & op_push_q;
            rx_pop  <= commit & op_pop_q;
            if (commit && op_push_q) begin
                tx_data <= PWDATA;
            end
            if (commit && op_wr_q) begin
                case (op_idx_q)
                    REG_PRESCALE: prescale_q <= PWDATA;
                    REG_COMMAND: begin
                        cmd_enable_q <= PWDATA[7];
                        cmd_rst_n_q  <= PWDATA[4];
                        cmd_rstart_q <= PWDATA[3];
                    end
                    REG_ADDRESS:  address_q <= PWDATA;
`ifdef I2C_APB_IRQ_EN
                    REG_IRQ_EN:   irq_en_q <= PWDATA[3:0];
`endif
                    default: ;
                endcase
            end
        end
    end

    // Sticky update: W1C clear from IRQ_STAT, a same-cycle set wins
    always_comb begin
        sticky_clr = '0;
        if (commit && op_wr_q && (op_idx_q == REG_IRQ_STAT)) begin
            sticky_clr = PWDATA[2:0];
        end
        sticky_set = {nack_rise_q, commit & op_ovf_q, commit & op_unf_q};
        sticky_d   = (sticky_q & ~sticky_clr) | sticky_set;
    end

    // nack edge detector and sticky error flags
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            nack_q      <= 1'b0;
            nack_rise_q <= 1'b0;
            sticky_q    <= '0;
        end else begin
            nack_q      <= nack;
            nack_rise_q <= nack & ~nack_q;
            sticky_q    <= sticky_d;
        end
    end

`ifdef I2C_APB_IRQ_EN
    // Interrupt from enabled stickies or RX data available
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq <= 1'b0;
        end else begin
            irq <= (|(irq_en_q[2:0] & sticky_q)) | (irq_en_q[3] & ~rx_empty);
        end
    end
`else
    assign irq = 1'b0;
`endif

    assign prescale_reg   = prescale_q;
    assign address_reg    = address_q;
    assign core_enable    = cmd_enable_q;
    assign core_rst_n     = cmd_rst_n_q;
    assign repeated_start = cmd_rstart_q;

endmodule

// File: tb/tb_apb_i2c_regfile.sv
// Self-checking bench for apb_i2c_regfile (WAIT_STATES=2) against a
// register-map level reference model; follows I2C_APB_IRQ_EN if defined.
module tb_apb_i2c_regfile;

    localparam int WS = 2;
`ifdef I2C_APB_IRQ_EN
    localparam bit IRQ_BUILT = 1'b1;
`else
    localparam bit IRQ_BUILT = 1'b0;
`endif

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       PSELx, PENABLE, PWRITE;
    logic [7:0] PADDR, PWDATA, PRDATA;
    logic       PREADY, PSLVERR;
    logic [7:0] prescale_reg, address_reg, tx_data, rx_data;
    logic       core_enable, core_rst_n, repeated_start;
    logic       tx_push, rx_pop, irq;
    logic       tx_full, tx_empty, rx_full, rx_empty, busy, nack;

    int checks   = 0;
    int failures = 0;
    int push_cnt = 0;
    int pop_cnt  = 0;

    // Reference model state
    logic [7:0] m_pre, m_adr, m_cmd, m_txd;
    logic [3:0] m_irqen;
    logic [2:0] m_st;
    int         m_push_tot = 0;
    int         m_pop_tot  = 0;

    apb_i2c_regfile #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(WS), .PRESCALE_RST(4)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(PSELx), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .prescale_reg(prescale_reg),
        .address_reg(address_reg), .core_enable(core_enable),
        .core_rst_n(core_rst_n), .repeated_start(repeated_start),
        .tx_data(tx_data), .tx_push(tx_push), .rx_pop(rx_pop),
        .rx_data(rx_data), .tx_full(tx_full), .tx_empty(tx_empty),
        .rx_full(rx_full), .rx_empty(rx_empty), .busy(busy), .nack(nack),
        .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (tx_push === 1'b1) push_cnt++;
        if (rx_pop === 1'b1) pop_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pre = 8'h04; m_adr = 8'h00; m_cmd = 8'h00; m_txd = 8'h00;
        m_irqen = 4'h0; m_st = 3'b000;
    endtask

    function automatic logic model_irq();
        return IRQ_BUILT & ((|(m_irqen[2:0] & m_st)) | (m_irqen[3] & ~rx_empty));
    endfunction

    // Register-map semantics of one APB transfer
    task automatic model_xfer(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                              output logic [7:0] rd, output logic er,
                              output logic ps, output logic po);
        rd = 8'h00; er = 1'b0; ps = 1'b0; po = 1'b0;
        if (a[7:3] != 5'd0) begin
            er = 1'b1;
        end else if (wr) begin
            case (a[2:0])
                3'd0: m_pre = wd;
                3'd1: m_cmd = wd & 8'h98;
                3'd3: if (tx_full) begin er = 1'b1; m_st[1] = 1'b1; end
                      else begin m_txd = wd; ps = 1'b1; m_push_tot++; end
                3'd5: m_adr = wd;
                3'd6: if (IRQ_BUILT) m_irqen = wd[3:0]; else er = 1'b1;
                3'd7: m_st = m_st & ~wd[2:0];
                default: er = 1'b1;
            endcase
        end else begin
            case (a[2:0])
                3'd0: rd = m_pre;
                3'd1: rd = m_cmd;
                3'd2: rd = {tx_full, tx_empty, rx_full, rx_empty, busy, m_st};
                3'd3: er = 1'b1;
                3'd4: if (rx_empty) begin er = 1'b1; m_st[0] = 1'b1; end
                      else begin rd = rx_data; po = 1'b1; m_pop_tot++; end
                3'd5: rd = m_adr;
                3'd6: rd = IRQ_BUILT ? {4'h0, m_irqen} : 8'h00;
                default: rd = {5'd0, m_st};
            endcase
        end
    endtask

    // One APB transfer; ncyc is the cycle (setup = 1) in which PREADY was seen
    task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                        output logic [7:0] rd, output logic er, output int ncyc);
        @(posedge PCLK); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
        ncyc = 1;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        ncyc = 2;
        while (PREADY !== 1'b1 && ncyc < 40) begin
            @(posedge PCLK); #1;
            ncyc++;
        end
        rd = PRDATA; er = PSLVERR;
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    logic [7:0] last_rd;

    task automatic run_xfer(input logic wr, input logic [7:0] a, input logic [7:0] wd);
        logic [7:0] rd, erd;
        logic       er, eer, ep, eo;
        int         n;
        model_xfer(wr, a, wd, erd, eer, ep, eo);
        xfer(wr, a, wd, rd, er, n);
        chk("ready_cycle", 32'(n), 32'(2 + WS));
        chk("pslverr", 32'(er), 32'(eer));
        chk("prdata", 32'(rd), 32'(erd));
        chk("tx_push_level", 32'(tx_push), 32'(ep));
        chk("rx_pop_level", 32'(rx_pop), 32'(eo));
        @(negedge PCLK); #1;
        chk("push_total", 32'(push_cnt), 32'(m_push_tot));
        chk("pop_total", 32'(pop_cnt), 32'(m_pop_tot));
        chk("prescale_reg", 32'(prescale_reg), 32'(m_pre));
        chk("address_reg", 32'(address_reg), 32'(m_adr));
        chk("command_out", 32'({core_enable, core_rst_n, repeated_start}),
            32'({m_cmd[7], m_cmd[4], m_cmd[3]}));
        chk("tx_data", 32'(tx_data), 32'(m_txd));
        last_rd = rd;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_prdata"}, 32'(PRDATA), 32'h0);
        chk({tag, "_pready"}, 32'(PREADY), 32'h0);
        chk({tag, "_pslverr"}, 32'(PSLVERR), 32'h0);
        chk({tag, "_tx_push"}, 32'(tx_push), 32'h0);
        chk({tag, "_rx_pop"}, 32'(rx_pop), 32'h0);
        chk({tag, "_irq"}, 32'(irq), 32'h0);
        chk({tag, "_prescale"}, 32'(prescale_reg), 32'h04);
        chk({tag, "_address"}, 32'(address_reg), 32'h0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'h0);
        chk({tag, "_command"}, 32'({core_enable, core_rst_n, repeated_start}), 32'h0);
    endtask

    initial begin
        logic [7:0] a, wd;
        logic       wr, nv, seen;
        int         push_before;

        PRESETn = 1'b0; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 8'h00; PWDATA = 8'h00; rx_data = 8'h00;
        tx_full = 1'b0; tx_empty = 1'b0; rx_full = 1'b0; rx_empty = 1'b0;
        busy = 1'b0; nack = 1'b0;
        model_reset();
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(negedge PCLK);
        chk_reset_outputs("reset");

        // Read every index after reset
        for (int i = 0; i < 8; i++) run_xfer(1'b0, 8'(i), 8'h00);

        // Wait-stated write
        run_xfer(1'b1, 8'h00, 8'h19);

        // TXDATA push, then overflow
        tx_full = 1'b0;
        run_xfer(1'b1, 8'h03, 8'hA5);
        tx_full = 1'b1;
        run_xfer(1'b1, 8'h03, 8'h5A);
        run_xfer(1'b0, 8'h02, 8'h00);
        chk("status_ovf_bit", 32'(last_rd[1]), 32'h1);

        // RXDATA pop, then underflow
        tx_full = 1'b0; rx_data = 8'h3C; rx_empty = 1'b0;
        run_xfer(1'b0, 8'h04, 8'h00);
        chk("rx_read_data", 32'(last_rd), 32'h3C);
        rx_empty = 1'b1;
        run_xfer(1'b0, 8'h04, 8'h00);
        run_xfer(1'b0, 8'h02, 8'h00);
        chk("status_unf_bit", 32'(last_rd[0]), 32'h1);

        // Illegal accesses and config writes
        run_xfer(1'b1, 8'h02, 8'hFF);
        run_xfer(1'b1, 8'h04, 8'hFF);
        run_xfer(1'b1, 8'h28, 8'h77);
        run_xfer(1'b0, 8'hF9, 8'h00);
        run_xfer(1'b1, 8'h01, 8'hFF);
        run_xfer(1'b1, 8'h05, 8'h50);
        run_xfer(1'b1, 8'h07, 8'h03);
        run_xfer(1'b1, 8'h06, 8'h04);

        // nack pulse raises the sticky and (when built) the interrupt
        @(posedge PCLK); #1;
        nack = 1'b1; m_st[2] = 1'b1;
        @(posedge PCLK); #1;
        nack = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge PCLK); #1;
            if (irq === 1'b1) seen = 1'b1;
        end
        chk("irq_after_nack", 32'(seen), 32'(model_irq()));
        run_xfer(1'b1, 8'h07, 8'h04);
        @(posedge PCLK); #1;
        chk("irq_after_clear", 32'(irq), 32'(model_irq()));
        run_xfer(1'b0, 8'h02, 8'h00);
        chk("status_nack_clear", 32'(last_rd[2]), 32'h0);

        // Randomized transfers against the model
        for (int it = 0; it < 120; it++) begin
            @(posedge PCLK); #1;
            chk("irq_rand", 32'(irq), 32'(model_irq()));
            tx_full  = 1'($urandom); tx_empty = 1'($urandom);
            rx_full  = 1'($urandom); rx_empty = 1'($urandom);
            busy     = 1'($urandom); rx_data  = 8'($urandom);
            nv = ($urandom_range(0, 3) == 0) ? ~nack : nack;
            if (nv && !nack) m_st[2] = 1'b1;
            nack = nv;
            repeat (2) @(posedge PCLK);
            wr = 1'($urandom);
            if ($urandom_range(0, 7) == 0) a = {5'($urandom_range(1, 31)), 3'($urandom)};
            else a = 8'($urandom_range(0, 7));
            wd = 8'($urandom);
            run_xfer(wr, a, wd);
        end

        // Reset during the access phase of a TXDATA write
        tx_full = 1'b0; nack = 1'b0;
        push_before = push_cnt;
        @(posedge PCLK); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h03; PWDATA = 8'hC3;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        PRESETn = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        model_reset();
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("midreset_no_push", 32'(push_cnt), 32'(push_before));
        chk_reset_outputs("after_midreset");
        run_xfer(1'b0, 8'h00, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
